// File: rtl/interrupt_sequencer_pkg.sv
// Shared encodings for the interrupt/reset entry sequencer: states, source
// types, push-source codes and the vector table.
package interrupt_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DUMMY  = 3'd1,
    ST_PUSH_H = 3'd2,
    ST_PUSH_L = 3'd3,
    ST_PUSH_P = 3'd4,
    ST_VEC_LO = 3'd5,
    ST_VEC_HI = 3'd6
  } seq_state_e;

  typedef enum logic [1:0] {
    SRC_RES = 2'd0,
    SRC_NMI = 2'd1,
    SRC_IRQ = 2'd2,
    SRC_BRK = 2'd3
  } src_type_e;

  localparam logic [1:0] DSEL_NONE = 2'd0;
  localparam logic [1:0] DSEL_PCH  = 2'd1;
  localparam logic [1:0] DSEL_PCL  = 2'd2;
  localparam logic [1:0] DSEL_P    = 2'd3;

  localparam logic [15:0] VEC_NMI = 16'hFFFA;
  localparam logic [15:0] VEC_RES = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ = 16'hFFFE;

  function automatic logic is_push(seq_state_e s);
    return (s == ST_PUSH_H) || (s == ST_PUSH_L) || (s == ST_PUSH_P);
  endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Bundle between the interrupt/reset controller side (master) and the
// sequencer (slave).
interface interrupt_sequencer_if;
  // rdy=1 lets DUMMY/VEC_LO/VEC_HI advance; rdy=0 stalls them. Push cycles
  // are writes and never stall on rdy.
  logic        nmi;
  logic        irq;
  logic        res;
  logic        iFlag;
  logic        brkOp;
  logic        opFetch;
  logic        rdy;
  logic        intActive;
  logic [2:0]  seqState;
  logic        spDec;
  logic        wrEn;
  logic [1:0]  dataSel;
  logic        bFlagOut;
  logic        setI;
  logic        vecLoadLo;
  logic        vecLoadHi;
  logic [15:0] vecAddr;
  logic        nmiHandled;
  logic        irqHandled;
  logic        resHandled;

  modport master (
    output nmi, irq, res, iFlag, brkOp, opFetch, rdy,
    input  intActive, seqState, spDec, wrEn, dataSel, bFlagOut, setI,
           vecLoadLo, vecLoadHi, vecAddr, nmiHandled, irqHandled, resHandled
  );

  modport slave (
    input  nmi, irq, res, iFlag, brkOp, opFetch, rdy,
    output intActive, seqState, spDec, wrEn, dataSel, bFlagOut, setI,
           vecLoadLo, vecLoadHi, vecAddr, nmiHandled, irqHandled, resHandled
  );
endinterface

// File: rtl/interrupt_sequencer_vector_select.sv
// Maps the latched source type and the hi/lo vector byte select to the
// vector fetch address.
module vector_select
  import interrupt_sequencer_pkg::*;
(
  input  src_type_e   src,
  input  logic        hi,
  output logic [15:0] addr
);

  logic [15:0] base;

  always_comb begin
    base = VEC_IRQ;
    case (src)
      SRC_NMI: base = VEC_NMI;
      SRC_RES: base = VEC_RES;
      default: base = VEC_IRQ;
    endcase
    addr = base | {15'd0, hi};
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// Seven-cycle RES/NMI/IRQ/BRK entry sequence: dummy read, three stack
// pushes, two vector fetches, with NMI hijack and reset abort.
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
(
  input  logic                  phi1,
  input  logic                  rstAll,
  interrupt_sequencer_if.slave  bus
);

  seq_state_e  state_q, state_d;
  src_type_e   src_q, src_d;
  logic        bflag_q, bflag_d;
  logic [15:0] vec_sel;

  always_ff @(posedge phi1 or posedge rstAll) begin
    if (rstAll) begin
      state_q <= ST_IDLE;
      src_q   <= SRC_RES;
      bflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      bflag_q <= bflag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    bflag_d = bflag_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.opFetch && bus.rdy) begin
          if (bus.res) begin
            src_d = SRC_RES; bflag_d = 1'b0; state_d = ST_DUMMY;
          end else if (bus.nmi) begin
            src_d = SRC_NMI; bflag_d = 1'b0; state_d = ST_DUMMY;
          end else if (bus.irq && !bus.iFlag) begin
            src_d = SRC_IRQ; bflag_d = 1'b0; state_d = ST_DUMMY;
          end else if (bus.brkOp) begin
            src_d = SRC_BRK; bflag_d = 1'b1; state_d = ST_DUMMY;
          end
        end
      end
      ST_DUMMY:  if (bus.rdy) state_d = ST_PUSH_H;
      ST_PUSH_H: state_d = ST_PUSH_L;
      ST_PUSH_L: state_d = ST_PUSH_P;
      ST_PUSH_P: state_d = ST_VEC_LO;
      ST_VEC_LO: if (bus.rdy) state_d = ST_VEC_HI;
      ST_VEC_HI: if (bus.rdy) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // The B bit stays with the latch, so a late hijack only redirects the vector.
    if (bus.nmi && (src_q == SRC_IRQ || src_q == SRC_BRK) &&
        (state_q == ST_DUMMY || is_push(state_q)))
      src_d = SRC_NMI;

    if (bus.res && state_q != ST_IDLE) begin
      state_d = ST_DUMMY;
      src_d   = SRC_RES;
      bflag_d = 1'b0;
    end
  end

  vector_select u_vector_select (
    .src  (src_q),
    .hi   (state_q == ST_VEC_HI),
    .addr (vec_sel)
  );

  always_comb begin
    bus.intActive  = (state_q != ST_IDLE);
    bus.seqState   = state_q;
    bus.spDec      = is_push(state_q);
    bus.wrEn       = is_push(state_q) && (src_q != SRC_RES);
    bus.dataSel    = DSEL_NONE;
    case (state_q)
      ST_PUSH_H: bus.dataSel = DSEL_PCH;
      ST_PUSH_L: bus.dataSel = DSEL_PCL;
      ST_PUSH_P: bus.dataSel = DSEL_P;
      default:   bus.dataSel = DSEL_NONE;
    endcase
    bus.bFlagOut   = (state_q == ST_PUSH_P) && bflag_q;
    bus.setI       = (state_q == ST_VEC_LO);
    bus.vecLoadLo  = (state_q == ST_VEC_LO) && bus.rdy;
    bus.vecLoadHi  = (state_q == ST_VEC_HI) && bus.rdy;
    bus.vecAddr    = (state_q == ST_VEC_LO || state_q == ST_VEC_HI) ? vec_sel : 16'h0000;
    bus.nmiHandled = (state_q == ST_VEC_HI) && (src_q == SRC_NMI);
    bus.irqHandled = (state_q == ST_VEC_HI) && (src_q == SRC_IRQ);
    bus.resHandled = (state_q == ST_VEC_HI) && (src_q == SRC_RES);
  end

endmodule

// File: doc/interrupt_sequencer.md
INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 The block SHALL have these ports, one per line, as name, direction, width, meaning:
- phi1  in  1  processor clock; all state advances on posedge phi1.
- rstAll  in  1  reset.
- nmi, irq, res  in  1 each  prioritised pending levels from the interrupt/reset controller.
- iFlag  in  1  P-register I bit; 1 masks irq.
- brkOp  in  1  decoded opcode is BRK (00); sampled with opFetch.
- opFetch  in  1  opcode-fetch cycle (instruction boundary) pulse.
- rdy  in  1  ready from ready control.
- intActive  out  1  sequence in progress; forces IR to 00 downstream.
- seqState  out  3  current state encoding.
- spDec  out  1  decrement stack pointer this cycle.
- wrEn  out  1  drive external write this cycle.
- dataSel  out  2  push source: 0 none, 1 PCH, 2 PCL, 3 P.
- bFlagOut  out  1  B bit value pushed with P.
- setI  out  1  set I flag this cycle.
- vecLoadLo, vecLoadHi  out  1 each  load PCL/PCH from data bus.
- vecAddr  out  16  vector address driven onto the address bus.
- nmiHandled, irqHandled, resHandled  out  1 each  one-cycle acknowledge pulses.
REQ-002 Reset SHALL be rstAll, asynchronous, active-high.

Function
REQ-003 States SHALL be IDLE, DUMMY, PUSH_H, PUSH_L, PUSH_P, VEC_LO, VEC_HI, encoded 0-6 on seqState.
REQ-004 Source selection in IDLE, at opFetch with rdy=1: res > nmi > (irq & ~iFlag) > brkOp; the first true one is latched as srcType (RES/NMI/IRQ/BRK).
REQ-005 If none of the four is true, the block SHALL remain in IDLE.
REQ-006 Traversal: IDLE->DUMMY->PUSH_H->PUSH_L->PUSH_P->VEC_LO->VEC_HI->IDLE, one state per phi1 with rdy=1.
- A sequence is 7 cycles, counting the opFetch cycle.
REQ-007 intActive SHALL be 1 in every non-IDLE state.
REQ-008 Push states:
- dataSel: PUSH_H=1, PUSH_L=2, PUSH_P=3.
- spDec=1 in each push state.
- wrEn=1 in each push state except for srcType RES, where wrEn=0 (reads only; SP still decrements by 3).
REQ-009 bFlagOut SHALL be 1 in PUSH_P when srcType=BRK, otherwise 0.
REQ-010 Vector addresses:
- VEC_LO: vecAddr = FFFA (NMI), FFFC (RES), FFFE (IRQ/BRK); vecLoadLo=1.
- VEC_HI: vecAddr = the VEC_LO address + 1; vecLoadHi=1.
REQ-011 setI SHALL be 1 in VEC_LO.
REQ-012 Handled pulses: in VEC_HI, exactly one of resHandled/nmiHandled/irqHandled SHALL pulse for one cycle, matching the final srcType; BRK pulses none.
REQ-013 NMI hijack: if nmi rises while srcType is IRQ or BRK and the state is DUMMY through PUSH_P:
- srcType becomes NMI; the vector becomes FFFA/FFFB.
- bFlagOut already committed in PUSH_P is unchanged.
- nmiHandled, not irqHandled, pulses.
REQ-014 An nmi arriving in VEC_LO or later SHALL not affect the current sequence; it is serviced at the next opFetch.
REQ-015 RDY rule: rdy=0 SHALL hold state and all outputs in DUMMY, VEC_LO and VEC_HI. Push states SHALL advance regardless of rdy, because writes ignore RDY.
REQ-016 res asserted in any non-IDLE state SHALL abort to DUMMY with srcType=RES on the next phi1; the push-write suppression of REQ-008 applies from that cycle.
REQ-017 Outputs SHALL be combinational decodes of the registered state, srcType and bFlag latch only; there are no combinational paths from inputs to outputs except rdy gating of the vecLoad strobes.

Reset
REQ-018 While rstAll=1, state SHALL be IDLE, srcType=RES, and every output SHALL be 0, including vecAddr=0000 and seqState=0.
REQ-019 After rstAll deasserts, the first opFetch with res=1 SHALL start a RES sequence.
REQ-020 No handled pulse SHALL be generated by reset itself.

Structure
REQ-021 State encodings, srcType encodings, dataSel codes and the vector constants FFFA/FFFC/FFFE SHALL live in a shared package used by the datapath and decoder.
REQ-022 A single sub-module, vector_select, SHALL map srcType and a hi/lo bit to vecAddr.
REQ-023 The block SHALL hold no other hierarchy.

Verification
REQ-024 rstAll pulse, then opFetch with res=1 -> states 1..6 with wrEn=0 throughout, spDec high 3 cycles, vecAddr FFFC then FFFD, one resHandled pulse.
REQ-025 irq=1, iFlag=0 at opFetch -> wrEn=1 on dataSel 1,2,3, bFlagOut=0, vecAddr FFFE/FFFF, setI in VEC_LO, irqHandled pulse.
REQ-026 irq=1, iFlag=1, brkOp=0 -> state stays IDLE and intActive=0; brkOp=1 instead -> BRK sequence with bFlagOut=1 in PUSH_P and no handled pulse.
REQ-027 IRQ sequence with nmi raised in PUSH_L -> vecAddr FFFA/FFFB, nmiHandled pulses, irqHandled stays 0.
REQ-028 rdy=0 for 3 cycles entering VEC_LO -> VEC_LO held 3 extra cycles; with rdy=0 during PUSH_H the sequence still advances.
REQ-029 res asserted during PUSH_H of an IRQ sequence -> next state DUMMY, wrEn=0 afterwards, vector FFFC, resHandled pulse.
